// File: rtl/glob_cmd_scheduler.sv
// glob_cmd_scheduler
// Global-side command scheduler for a ring of local prefetch controllers.
// Host commands are buffered in an in-order FIFO and issued one per cycle at
// most, as one-cycle strobes, with a minimum spacing per target controller.
// A scenario request drains all pending work, waits for every cooldown to
// expire, then emits a single-cycle scenario_update strobe.
//
// Ports
//   CLK, reset             clock, synchronous active-high reset
//   cmd_valid/cmd_ready    host command handshake
//   cmd_type               0 = delay/dest, 1 = prefetch
//   cmd_target             target controller index
//   cmd_addr_a/_b, cmd_dest command payload
//   scenario_req           request a scenario update
//   glob_controller_*      one-hot delay/dest issue strobe and data buses
//   glob_prefetch_*        one-hot prefetch issue strobe and data buses
//   scenario_update        one-cycle strobe to all controllers
//   busy                   work pending, cooling, or scenario sequence active
module glob_cmd_scheduler #(
  parameter int unsigned address_vector_width = 8,
  parameter int unsigned sample_address_width = 8,
  parameter int unsigned n_ctrl               = 4,
  parameter int unsigned fifo_depth           = 4,
  parameter int unsigned min_gap              = 4
) (
  input  logic                            CLK,
  input  logic                            reset,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_type,
  input  logic [1:0]                      cmd_target,
  input  logic [sample_address_width-1:0] cmd_addr_a,
  input  logic [sample_address_width-1:0] cmd_addr_b,
  input  logic [address_vector_width-1:0] cmd_dest,
  input  logic                            scenario_req,
  output logic [n_ctrl-1:0]               glob_controller_valid,
  output logic [sample_address_width-1:0] glob_controller_delay,
  output logic [address_vector_width-1:0] glob_dest_addr,
  output logic [n_ctrl-1:0]               glob_prefetch_valid,
  output logic [sample_address_width-1:0] glob_prefetch_start,
  output logic [sample_address_width-1:0] glob_prefetch_stop,
  output logic [address_vector_width-1:0] glob_prefetch_dest,
  output logic                            scenario_update,
  output logic                            busy
);

  localparam int unsigned TGT_W = 2;
  localparam int unsigned CD_W  = $clog2(min_gap + 1);
  localparam int unsigned PTR_W = $clog2(fifo_depth);
  localparam int unsigned CNT_W = $clog2(fifo_depth + 1);

  typedef struct packed {
    logic                            typ;
    logic [TGT_W-1:0]                target;
    logic [sample_address_width-1:0] addr_a;
    logic [sample_address_width-1:0] addr_b;
    logic [address_vector_width-1:0] dest;
  } cmd_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAIN,
    S_WAIT,
    S_UPDATE
  } state_e;

  // Storage and control state
  cmd_t             mem_q [fifo_depth];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CD_W-1:0]  cd_q [n_ctrl];
  logic [CD_W-1:0]  cd_d [n_ctrl];
  state_e           state_q, state_d;

  // Registered outputs
  logic [n_ctrl-1:0]               ctrl_valid_q, ctrl_valid_d;
  logic [sample_address_width-1:0] delay_q, delay_d;
  logic [address_vector_width-1:0] dest_q, dest_d;
  logic [n_ctrl-1:0]               pf_valid_q, pf_valid_d;
  logic [sample_address_width-1:0] pf_start_q, pf_start_d;
  logic [sample_address_width-1:0] pf_stop_q, pf_stop_d;
  logic [address_vector_width-1:0] pf_dest_q, pf_dest_d;
  logic                            update_q, update_d;
  logic                            busy_q, busy_d;
  logic                            ready_q, ready_d;

  // Combinational helpers
  cmd_t              cmd_in_c;
  cmd_t              head_c;
  logic              push_c;
  logic              issue_c;
  logic              cd_all_zero_c;
  logic              cd_any_next_c;
  logic [n_ctrl-1:0] onehot_c;

  assign cmd_in_c = {cmd_type, cmd_target, cmd_addr_a, cmd_addr_b, cmd_dest};
  assign head_c   = mem_q[rd_ptr_q];
  assign push_c   = cmd_valid && ready_q;
  // Strict in-order issue: a cooling head blocks everything behind it.
  assign issue_c  = (count_q != '0) && (cd_q[head_c.target] == '0);

  // Scenario sequencing
  always_comb begin
    cd_all_zero_c = 1'b1;
    for (int k = 0; k < n_ctrl; k++) begin
      if (cd_q[k] != '0) cd_all_zero_c = 1'b0;
    end
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (scenario_req) state_d = S_DRAIN;
      S_DRAIN:  if (count_q == '0) state_d = S_WAIT;
      S_WAIT:   if (cd_all_zero_c) state_d = S_UPDATE;
      S_UPDATE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FIFO pointers/occupancy and per-controller cooldowns
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_c) wr_ptr_d = PTR_W'(wr_ptr_q + 1'b1);
    if (issue_c) rd_ptr_d = PTR_W'(rd_ptr_q + 1'b1);
    unique case ({push_c, issue_c})
      2'b10:   count_d = CNT_W'(count_q + 1'b1);
      2'b01:   count_d = CNT_W'(count_q - 1'b1);
      default: count_d = count_q;
    endcase

    cd_any_next_c = 1'b0;
    for (int k = 0; k < n_ctrl; k++) begin
      cd_d[k] = (cd_q[k] != '0) ? CD_W'(cd_q[k] - 1'b1) : '0;
    end
    // Loading min_gap-1 here yields exactly min_gap edges between issues.
    if (issue_c) cd_d[head_c.target] = CD_W'(min_gap - 1);
    for (int k = 0; k < n_ctrl; k++) begin
      if (cd_d[k] != '0) cd_any_next_c = 1'b1;
    end
  end

  // Issue strobes and data buses; idle buses are driven to zero
  always_comb begin
    onehot_c     = '0;
    ctrl_valid_d = '0;
    delay_d      = '0;
    dest_d       = '0;
    pf_valid_d   = '0;
    pf_start_d   = '0;
    pf_stop_d    = '0;
    pf_dest_d    = '0;
    onehot_c[head_c.target] = 1'b1;
    if (issue_c) begin
      if (head_c.typ) begin
        pf_valid_d = onehot_c;
        pf_start_d = head_c.addr_a;
        pf_stop_d  = head_c.addr_b;
        pf_dest_d  = head_c.dest;
      end else begin
        ctrl_valid_d = onehot_c;
        delay_d      = head_c.addr_a;
        dest_d       = head_c.dest;
      end
    end
    update_d = (state_d == S_UPDATE);
    busy_d   = (count_d != '0) || cd_any_next_c || (state_d != S_IDLE);
    ready_d  = (count_d != CNT_W'(fifo_depth)) && (state_d == S_IDLE);
  end

  // FIFO payload storage; contents are don't-care while the FIFO is empty
  always_ff @(posedge CLK) begin
    if (push_c) mem_q[wr_ptr_q] <= cmd_in_c;
  end

  // State and output registers
  always_ff @(posedge CLK) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      state_q      <= S_IDLE;
      for (int k = 0; k < n_ctrl; k++) cd_q[k] <= '0;
      ctrl_valid_q <= '0;
      delay_q      <= '0;
      dest_q       <= '0;
      pf_valid_q   <= '0;
      pf_start_q   <= '0;
      pf_stop_q    <= '0;
      pf_dest_q    <= '0;
      update_q     <= 1'b0;
      busy_q       <= 1'b0;
      ready_q      <= 1'b1;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      state_q      <= state_d;
      for (int k = 0; k < n_ctrl; k++) cd_q[k] <= cd_d[k];
      ctrl_valid_q <= ctrl_valid_d;
      delay_q      <= delay_d;
      dest_q       <= dest_d;
      pf_valid_q   <= pf_valid_d;
      pf_start_q   <= pf_start_d;
      pf_stop_q    <= pf_stop_d;
      pf_dest_q    <= pf_dest_d;
      update_q     <= update_d;
      busy_q       <= busy_d;
      ready_q      <= ready_d;
    end
  end

  assign cmd_ready             = ready_q;
  assign glob_controller_valid = ctrl_valid_q;
  assign glob_controller_delay = delay_q;
  assign glob_dest_addr        = dest_q;
  assign glob_prefetch_valid   = pf_valid_q;
  assign glob_prefetch_start   = pf_start_q;
  assign glob_prefetch_stop    = pf_stop_q;
  assign glob_prefetch_dest    = pf_dest_q;
  assign scenario_update       = update_q;
  assign busy                  = busy_q;

endmodule

// File: tb/tb_glob_cmd_scheduler.sv
// Self-checking bench for glob_cmd_scheduler: accepted commands are queued as
// expected issues and compared in order when strobes appear.
module tb_glob_cmd_scheduler;

  localparam int unsigned GAP = 4;

  typedef struct packed {
    logic       typ;
    logic [1:0] tgt;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] d;
  } cmd_s;

  logic       CLK = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_type = 1'b0;
  logic [1:0] cmd_target = '0;
  logic [7:0] cmd_addr_a = '0;
  logic [7:0] cmd_addr_b = '0;
  logic [7:0] cmd_dest = '0;
  logic       scenario_req = 1'b0;
  logic [3:0] glob_controller_valid;
  logic [7:0] glob_controller_delay;
  logic [7:0] glob_dest_addr;
  logic [3:0] glob_prefetch_valid;
  logic [7:0] glob_prefetch_start;
  logic [7:0] glob_prefetch_stop;
  logic [7:0] glob_prefetch_dest;
  logic       scenario_update;
  logic       busy;

  glob_cmd_scheduler dut (
    .CLK                   (CLK),
    .reset                 (reset),
    .cmd_valid             (cmd_valid),
    .cmd_ready             (cmd_ready),
    .cmd_type              (cmd_type),
    .cmd_target            (cmd_target),
    .cmd_addr_a            (cmd_addr_a),
    .cmd_addr_b            (cmd_addr_b),
    .cmd_dest              (cmd_dest),
    .scenario_req          (scenario_req),
    .glob_controller_valid (glob_controller_valid),
    .glob_controller_delay (glob_controller_delay),
    .glob_dest_addr        (glob_dest_addr),
    .glob_prefetch_valid   (glob_prefetch_valid),
    .glob_prefetch_start   (glob_prefetch_start),
    .glob_prefetch_stop    (glob_prefetch_stop),
    .glob_prefetch_dest    (glob_prefetch_dest),
    .scenario_update       (scenario_update),
    .busy                  (busy)
  );

  always #5 CLK = ~CLK;

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned n_upd    = 0;
  int unsigned acc_cyc  = 0;
  cmd_s        sb_q[$];
  int unsigned iss_cyc_q[$];
  logic [1:0]  iss_tgt_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int unsigned iss_at(input int i);
    if (i < iss_cyc_q.size()) return iss_cyc_q[i];
    return 0;
  endfunction

  function automatic logic [1:0] tgt_at(input int i);
    if (i < iss_tgt_q.size()) return iss_tgt_q[i];
    return 2'bxx;
  endfunction

  // Output monitor, sampling 2 time units after each rising edge
  cmd_s        mon_e;
  logic [3:0]  exp_cv, exp_pv;
  int unsigned last_iss [4];
  bit          seen_iss [4];
  always @(posedge CLK) begin
    #2;
    if (reset) begin
      for (int k = 0; k < 4; k++) seen_iss[k] = 1'b0;
    end else begin
      if (scenario_update) n_upd++;
      if ((glob_controller_valid | glob_prefetch_valid) != 4'b0) begin
        check("one_hot", $countones({glob_controller_valid, glob_prefetch_valid}), 1);
        check("update_with_valid", 32'(scenario_update), 0);
        if (sb_q.size() == 0) begin
          check("unexpected_issue", {glob_controller_valid, glob_prefetch_valid}, 0);
        end else begin
          mon_e  = sb_q.pop_front();
          exp_cv = '0;
          exp_pv = '0;
          if (mon_e.typ) exp_pv[mon_e.tgt] = 1'b1;
          else           exp_cv[mon_e.tgt] = 1'b1;
          check("ctrl_valid", 32'(glob_controller_valid), 32'(exp_cv));
          check("pf_valid", 32'(glob_prefetch_valid), 32'(exp_pv));
          if (mon_e.typ) begin
            check("pf_start", 32'(glob_prefetch_start), 32'(mon_e.a));
            check("pf_stop", 32'(glob_prefetch_stop), 32'(mon_e.b));
            check("pf_dest", 32'(glob_prefetch_dest), 32'(mon_e.d));
            check("ctrl_bus_zero", {glob_controller_delay, glob_dest_addr}, 0);
          end else begin
            check("delay", 32'(glob_controller_delay), 32'(mon_e.a));
            check("dest", 32'(glob_dest_addr), 32'(mon_e.d));
            check("pf_bus_zero", {glob_prefetch_start, glob_prefetch_stop, glob_prefetch_dest}, 0);
          end
          if (seen_iss[mon_e.tgt]) check("same_target_gap", 32'((cyc - last_iss[mon_e.tgt]) >= GAP), 1);
          seen_iss[mon_e.tgt] = 1'b1;
          last_iss[mon_e.tgt] = cyc;
          iss_cyc_q.push_back(cyc);
          iss_tgt_q.push_back(mon_e.tgt);
        end
      end else begin
        check("idle_bus_zero", 32'(|{glob_controller_delay, glob_dest_addr, glob_prefetch_start,
                                    glob_prefetch_stop, glob_prefetch_dest}), 0);
      end
    end
  end

  // Present one command (called at a falling edge) until it is accepted
  task automatic push(input logic typ, input logic [1:0] tgt, input logic [7:0] a,
                      input logic [7:0] b, input logic [7:0] d);
    cmd_s e;
    bit   ok = 1'b0;
    e = {typ, tgt, a, b, d};
    cmd_valid  = 1'b1;
    cmd_type   = typ;
    cmd_target = tgt;
    cmd_addr_a = a;
    cmd_addr_b = b;
    cmd_dest   = d;
    for (int i = 0; i < 64 && !ok; i++) begin
      if (cmd_ready) begin
        acc_cyc = cyc + 1;
        sb_q.push_back(e);
        ok = 1'b1;
      end
      @(negedge CLK);
    end
    cmd_valid = 1'b0;
    check("push_accepted", 32'(ok), 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300 && (busy || sb_q.size() != 0); i++) @(negedge CLK);
    check("idle_busy", 32'(busy), 0);
    check("idle_sb_empty", sb_q.size(), 0);
  endtask

  task automatic clear_log();
    iss_cyc_q.delete();
    iss_tgt_q.delete();
  endtask

  task automatic wait_update(output int unsigned up);
    bit got = 1'b0;
    up = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge CLK);
      if (scenario_update) begin
        got = 1'b1;
        up  = cyc;
      end
    end
    check("update_seen", 32'(got), 1);
  endtask

  int unsigned a0, up, upd0;

  initial begin
    repeat (3) @(negedge CLK);
    reset = 1'b0;
    @(negedge CLK);
    check("rst_ctrl_valid", 32'(glob_controller_valid), 0);
    check("rst_pf_valid", 32'(glob_prefetch_valid), 0);
    check("rst_buses", {glob_controller_delay, glob_dest_addr, glob_prefetch_start, glob_prefetch_stop}, 0);
    check("rst_pf_dest", 32'(glob_prefetch_dest), 0);
    check("rst_update", 32'(scenario_update), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_ready", 32'(cmd_ready), 1);

    // Single delay command
    clear_log();
    push(1'b0, 2'd2, 8'h19, 8'h00, 8'h08);
    a0 = acc_cyc;
    wait_idle();
    check("single_count", iss_cyc_q.size(), 1);
    check("single_latency", iss_at(0) - a0, 1);
    check("single_target", 32'(tgt_at(0)), 2);

    // Same-target prefetch spacing
    clear_log();
    push(1'b1, 2'd3, 8'h30, 8'hE0, 8'h6F);
    a0 = acc_cyc;
    push(1'b1, 2'd3, 8'h31, 8'hE0, 8'h6F);
    push(1'b1, 2'd3, 8'h32, 8'hE0, 8'h6F);
    wait_idle();
    check("spacing_count", iss_cyc_q.size(), 3);
    check("spacing_latency", iss_at(0) - a0, 1);
    check("spacing_gap1", iss_at(1) - iss_at(0), GAP);
    check("spacing_gap2", iss_at(2) - iss_at(1), GAP);

    // Head-of-line stall: 0, 0, 1
    clear_log();
    push(1'b0, 2'd0, 8'h10, 8'h00, 8'h01);
    push(1'b0, 2'd0, 8'h11, 8'h00, 8'h02);
    push(1'b0, 2'd1, 8'h12, 8'h00, 8'h03);
    wait_idle();
    check("hol_count", iss_cyc_q.size(), 3);
    check("hol_order2", 32'(tgt_at(2)), 1);
    check("hol_gap_t0", iss_at(1) - iss_at(0), GAP);
    check("hol_t1_after", iss_at(2) - iss_at(1), 1);

    // Full FIFO: lead-in issues, then four commands pile up behind the cooldown
    clear_log();
    push(1'b0, 2'd0, 8'h40, 8'h00, 8'h10);
    push(1'b0, 2'd0, 8'h41, 8'h00, 8'h11);
    push(1'b0, 2'd0, 8'h42, 8'h00, 8'h12);
    push(1'b0, 2'd0, 8'h43, 8'h00, 8'h13);
    push(1'b0, 2'd0, 8'h44, 8'h00, 8'h14);
    check("full_ready_low", 32'(cmd_ready), 0);
    check("full_busy", 32'(busy), 1);
    push(1'b0, 2'd0, 8'h45, 8'h00, 8'h15);
    a0 = acc_cyc;
    wait_idle();
    check("full_count", iss_cyc_q.size(), 6);
    check("full_accept_after_pop", a0 - iss_at(1), 1);

    // Scenario request with nothing pending
    scenario_req = 1'b1;
    a0 = cyc + 1;
    @(negedge CLK);
    scenario_req = 1'b0;
    check("scn_empty_ready", 32'(cmd_ready), 0);
    check("scn_empty_busy", 32'(busy), 1);
    wait_update(up);
    check("scn_empty_latency", up - a0, 2);
    @(negedge CLK);
    check("scn_empty_strobe_len", 32'(scenario_update), 0);
    check("scn_empty_ready_back", 32'(cmd_ready), 1);
    check("scn_empty_idle", 32'(busy), 0);

    // Scenario drain with two queued commands; a second request is ignored
    clear_log();
    upd0 = n_upd;
    push(1'b0, 2'd1, 8'h20, 8'h00, 8'h05);
    scenario_req = 1'b1;
    push(1'b0, 2'd1, 8'h21, 8'h00, 8'h06);
    scenario_req = 1'b0;
    check("drain_ready_low", 32'(cmd_ready), 0);
    scenario_req = 1'b1;
    @(negedge CLK);
    scenario_req = 1'b0;
    wait_update(up);
    check("drain_count", iss_cyc_q.size(), 2);
    check("drain_update_delay", up - iss_at(1), GAP);
    @(negedge CLK);
    check("drain_strobe_len", 32'(scenario_update), 0);
    check("drain_ready_back", 32'(cmd_ready), 1);
    check("drain_idle", 32'(busy), 0);
    repeat (8) @(negedge CLK);
    check("drain_single_update", n_upd - upd0, 1);

    // Reset mid-queue, with a command presented during reset
    clear_log();
    push(1'b0, 2'd0, 8'h50, 8'h00, 8'h20);
    push(1'b0, 2'd0, 8'h51, 8'h00, 8'h21);
    push(1'b0, 2'd0, 8'h52, 8'h00, 8'h22);
    reset      = 1'b1;
    cmd_valid  = 1'b1;
    cmd_type   = 1'b1;
    cmd_target = 2'd3;
    cmd_addr_a = 8'h77;
    repeat (2) @(negedge CLK);
    reset     = 1'b0;
    cmd_valid = 1'b0;
    sb_q.delete();
    clear_log();
    @(negedge CLK);
    check("rst2_busy", 32'(busy), 0);
    check("rst2_ready", 32'(cmd_ready), 1);
    check("rst2_valids", {glob_controller_valid, glob_prefetch_valid}, 0);
    repeat (6) @(negedge CLK);
    check("rst2_no_pulses", iss_cyc_q.size(), 0);
    push(1'b0, 2'd3, 8'h44, 8'h00, 8'h0C);
    a0 = acc_cyc;
    wait_idle();
    check("rst2_count", iss_cyc_q.size(), 1);
    check("rst2_latency", iss_at(0) - a0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
